// File: rtl/actuator_spi_pattern_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : actuator_spi_pattern_rx_if
//  Purpose  : Bundles the actuator SPI pins and the output-enable and latch
//             strobes that travel between the padframe wrapper and the
//             actuator pattern receiver.
//  Signals  : sclk, mosi, ss_n  - SPI clock, data in and select (raw pins)
//             latch_data_n      - shadow-to-active transfer strobe (raw pin)
//             enable_n          - global output enable (raw pin)
//             miso              - SPI data out
//  Modports : master - pin driver side (padframe or test stimulus)
//             slave  - receiver side
//  Revision : 1.0 - initial release
// ============================================================================
interface actuator_spi_pattern_rx_if;
    logic sclk;
    logic mosi;
    logic ss_n;
    logic latch_data_n;
    logic enable_n;
    logic miso;

    modport master (
        output sclk, mosi, ss_n, latch_data_n, enable_n,
        input  miso
    );

    modport slave (
        input  sclk, mosi, ss_n, latch_data_n, enable_n,
        output miso
    );
endinterface
`default_nettype wire

// File: rtl/actuator_spi_pattern_rx.sv
`default_nettype none
// ============================================================================
//  Module   : actuator_spi_pattern_rx
//  Purpose  : SPI slave (mode 0, MSB first) that decodes 16-bit command
//             frames into shadow row/column H-bridge registers. A falling
//             edge on latch_data_n copies the shadow set into the active set,
//             which drives the H-bridge codes and enables.
//  Ports    : clock        - system clock, at least 4x sclk
//             reset_n      - asynchronous active-low reset
//             spi          - pin bundle (sclk, mosi, ss_n, latch_data_n,
//                            enable_n in; miso out)
//             rows_hbrige  - row codes, row r on bits [2r+1:2r]
//             cols_hbrige  - column codes, column c on bits [2c+1:2c]
//             rows_enable  - row enables
//             cols_enable  - column enables
//             frame_err    - sticky error flag
//  Options  : SPI_READBACK_EN - when defined, cmd 0x3 reads back a shadow
//             register in the response following the READ frame.
//  Revision : 1.0 - initial release
// ============================================================================
module actuator_spi_pattern_rx #(
    parameter int NUM_ROWS = 5,
    parameter int NUM_COLS = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    actuator_spi_pattern_rx_if.slave spi,
    output logic [2*NUM_ROWS-1:0]   rows_hbrige,
    output logic [2*NUM_COLS-1:0]   cols_hbrige,
    output logic [NUM_ROWS-1:0]     rows_enable,
    output logic [NUM_COLS-1:0]     cols_enable,
    output logic                    frame_err
);

    localparam logic [3:0] CMD_NOP   = 4'h0;
    localparam logic [3:0] CMD_ROW   = 4'h1;
    localparam logic [3:0] CMD_COL   = 4'h2;
    localparam logic [3:0] CMD_CLEAR = 4'h4;
`ifdef SPI_READBACK_EN
    localparam logic [3:0] CMD_READ  = 4'h3;
`endif

    // Synchronizer bit order: {enable_n, latch_data_n, ss_n, mosi, sclk}
    logic [4:0]  sync_1;
    logic [4:0]  sync_2;
    logic [2:0]  prev;          // previous synced {latch_data_n, ss_n, sclk}

    logic        sclk_s, mosi_s, ss_s, latch_s, enable_s;
    logic        sclk_rise, sclk_fall, ss_fall, ss_rise, latch_fall;

    logic [3:0]  bit_cnt;
    logic [15:0] rx_shift;
    logic [15:0] tx_shift;
    logic        frame_done;    // decode strobe, one clock after the wrap
    logic        skip_shift;    // swallow the falling edge right after a load
    logic [7:0]  frame_cnt;

    logic [2:0]  shadow_row [NUM_ROWS];
    logic [2:0]  shadow_col [NUM_COLS];
    logic [2:0]  active_row [NUM_ROWS];
    logic [2:0]  active_col [NUM_COLS];

    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [2:0]  field;
    logic        row_we, col_we, clear_all, bad_frame, rd_sel;
    logic [15:0] rd_word;
    logic        err_next;
    logic [7:0]  cnt_next;
    logic [15:0] status_word;
    logic        unused_rx_bits;

    assign sclk_s   = sync_2[0];
    assign mosi_s   = sync_2[1];
    assign ss_s     = sync_2[2];
    assign latch_s  = sync_2[3];
    assign enable_s = sync_2[4];

    assign sclk_rise  =  sclk_s  & ~prev[0];
    assign sclk_fall  = ~sclk_s  &  prev[0];
    assign ss_rise    =  ss_s    & ~prev[1];
    assign ss_fall    = ~ss_s    &  prev[1];
    assign latch_fall = ~latch_s &  prev[2];

    assign cmd            = rx_shift[15:12];
    assign addr           = rx_shift[11:8];
    assign field          = {rx_shift[7], rx_shift[1:0]};
    assign unused_rx_bits = ^rx_shift[6:2];

    // Frame decode; only acted on while frame_done is high
    always_comb begin
        row_we    = 1'b0;
        col_we    = 1'b0;
        clear_all = 1'b0;
        bad_frame = 1'b0;
        rd_sel    = 1'b0;
        rd_word   = 16'h0000;
        case (cmd)
            CMD_NOP: ;
            CMD_ROW: begin
                if (int'(addr) < NUM_ROWS) row_we = 1'b1;
                else                       bad_frame = 1'b1;
            end
            CMD_COL: begin
                if (int'(addr) < NUM_COLS) col_we = 1'b1;
                else                       bad_frame = 1'b1;
            end
            CMD_CLEAR: clear_all = 1'b1;
`ifdef SPI_READBACK_EN
            CMD_READ: begin
                bad_frame = 1'b1;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if (int'(addr) == r) begin
                        rd_word   = {4'h5, addr, 5'b00000, shadow_row[r]};
                        rd_sel    = 1'b1;
                        bad_frame = 1'b0;
                    end
                end
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (int'(addr) == 8 + c) begin
                        rd_word   = {4'h5, addr, 5'b00000, shadow_col[c]};
                        rd_sel    = 1'b1;
                        bad_frame = 1'b0;
                    end
                end
            end
`endif
            default: bad_frame = 1'b1;
        endcase
    end

    // Status reflects the error/count state including the frame just decoded
    assign err_next    = frame_err | (frame_done & bad_frame) | (ss_rise & (bit_cnt != 4'd0));
    assign cnt_next    = frame_cnt + {7'd0, frame_done};
    assign status_word = {4'hA, 3'b000, err_next, cnt_next};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1     <= '0;
            sync_2     <= '0;
            prev       <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            frame_done <= 1'b0;
            skip_shift <= 1'b0;
            frame_cnt  <= '0;
            frame_err  <= 1'b0;
            shadow_row <= '{default: '0};
            shadow_col <= '{default: '0};
            active_row <= '{default: '0};
            active_col <= '{default: '0};
        end else begin
            sync_1    <= {spi.enable_n, spi.latch_data_n, spi.ss_n, spi.mosi, spi.sclk};
            sync_2    <= sync_1;
            prev      <= {latch_s, ss_s, sclk_s};
            frame_err <= err_next;
            frame_cnt <= cnt_next;

            // Receive path; a deselect throws away any partial frame
            if (ss_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                rx_shift <= {rx_shift[14:0], mosi_s};
                bit_cnt  <= bit_cnt + 4'd1;
            end
            frame_done <= ~ss_s & sclk_rise & (bit_cnt == 4'd15);

            // Transmit path. The response is loaded before the falling edge
            // that closes the frame, so that edge must not shift it.
            if (ss_s) begin
                tx_shift   <= '0;
                skip_shift <= 1'b0;
            end else if (ss_fall) begin
                tx_shift   <= status_word;
                skip_shift <= 1'b0;
            end else if (frame_done) begin
                tx_shift   <= rd_sel ? rd_word : status_word;
                skip_shift <= 1'b1;
            end else if (sclk_fall) begin
                if (skip_shift) skip_shift <= 1'b0;
                else            tx_shift   <= {tx_shift[14:0], 1'b0};
            end

            // Shadow update; the latch reads pre-write shadow values
            if (frame_done) begin
                if (clear_all) begin
                    shadow_row <= '{default: '0};
                    shadow_col <= '{default: '0};
                end
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if (row_we && int'(addr) == r) shadow_row[r] <= field;
                end
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (col_we && int'(addr) == c) shadow_col[c] <= field;
                end
            end

            if (latch_fall) begin
                active_row <= shadow_row;
                active_col <= shadow_col;
            end
        end
    end

    assign spi.miso = tx_shift[15] & ~ss_s;

    // A channel drives only when globally enabled and its own en bit is set
    always_comb begin
        rows_hbrige = '0;
        rows_enable = '0;
        cols_hbrige = '0;
        cols_enable = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!enable_s && active_row[r][2]) begin
                rows_hbrige[2*r +: 2] = active_row[r][1:0];
                rows_enable[r]        = 1'b1;
            end
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!enable_s && active_col[c][2]) begin
                cols_hbrige[2*c +: 2] = active_col[c][1:0];
                cols_enable[c]        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_actuator_spi_pattern_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_actuator_spi_pattern_rx
//  Purpose  : Directed self-checking bench for actuator_spi_pattern_rx.
//             Expected MISO words are queued when a frame starts and compared
//             when the frame has been clocked out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_actuator_spi_pattern_rx;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 2;
    localparam int HALF     = 6;   // system clocks per sclk half period

    logic clock;
    logic reset_n;
    logic [2*NUM_ROWS-1:0] rows_hbrige;
    logic [2*NUM_COLS-1:0] cols_hbrige;
    logic [NUM_ROWS-1:0]   rows_enable;
    logic [NUM_COLS-1:0]   cols_enable;
    logic                  frame_err;

    actuator_spi_pattern_rx_if spi ();

    actuator_spi_pattern_rx #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .spi         (spi),
        .rows_hbrige (rows_hbrige),
        .cols_hbrige (cols_hbrige),
        .rows_enable (rows_enable),
        .cols_enable (cols_enable),
        .frame_err   (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];     // expected MISO words
    logic        m_err;     // model of the sticky error flag
    logic [7:0]  m_cnt;     // model of the frame counter

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [15:0] status_word();
        return {4'hA, 3'b000, m_err, m_cnt};
    endfunction

    // Reference view of what a complete frame does to the error/count state
    task automatic model_frame(input logic [15:0] w);
        logic [3:0] c;
        logic [3:0] a;
        c = w[15:12];
        a = w[11:8];
        m_cnt = m_cnt + 8'd1;
        if (!(c == 4'h0 || c == 4'h1 || c == 4'h2 || c == 4'h4)) m_err = 1'b1;
        if (c == 4'h1 && a >= 4'd5) m_err = 1'b1;
        if (c == 4'h2 && a >= 4'd2) m_err = 1'b1;
    endtask

    task automatic send_word(input string tag, input logic [15:0] w);
        logic [15:0] got;
        logic [15:0] exp;
        got = '0;
        for (int i = 15; i >= 0; i--) begin
            spi.mosi = w[i];
            wait_clk(HALF);
            got[i]   = spi.miso;
            spi.sclk = 1'b1;
            wait_clk(HALF);
            spi.sclk = 1'b0;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_miso"}, {16'd0, got}, {16'd0, exp});
        end
        model_frame(w);
    endtask

    task automatic session(input string tag, input int n, input logic [15:0] w0, input logic [15:0] w1);
        spi.ss_n = 1'b0;
        sb.push_back(status_word());
        wait_clk(HALF);
        send_word({tag, "_f0"}, w0);
        if (n > 1) begin
            sb.push_back(status_word());
            send_word({tag, "_f1"}, w1);
        end
        wait_clk(HALF);
        spi.ss_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic latch_pulse();
        spi.latch_data_n = 1'b0;
        wait_clk(4);
        spi.latch_data_n = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        spi.sclk         = 1'b0;
        spi.mosi         = 1'b0;
        spi.ss_n         = 1'b1;
        spi.latch_data_n = 1'b1;
        spi.enable_n     = 1'b0;
        reset_n          = 1'b0;
        m_err            = 1'b0;
        m_cnt            = 8'd0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(6);

        // Reset state
        chk("rst_rows", {22'd0, rows_hbrige}, 32'h0);
        chk("rst_rows_en", {27'd0, rows_enable}, 32'h0);
        chk("rst_cols", {28'd0, cols_hbrige}, 32'h0);
        chk("rst_cols_en", {30'd0, cols_enable}, 32'h0);
        chk("rst_err", {31'd0, frame_err}, 32'h0);
        chk("rst_miso", {31'd0, spi.miso}, 32'h0);

        // Row 0, en, code 2
        session("row0", 1, 16'h1082, 16'h0);
        latch_pulse();
        chk("row0_rows", {22'd0, rows_hbrige}, 32'h002);
        chk("row0_rows_en", {27'd0, rows_enable}, 32'h01);
        chk("row0_cols", {28'd0, cols_hbrige}, 32'h0);
        chk("row0_cols_en", {30'd0, cols_enable}, 32'h0);
        chk("row0_err", {31'd0, frame_err}, 32'h0);

        // Row 1 sits in shadow until the latch
        session("row1", 1, 16'h1182, 16'h0);
        chk("row1_prelatch", {22'd0, rows_hbrige}, 32'h002);
        latch_pulse();
        chk("row1_rows", {22'd0, rows_hbrige}, 32'h00A);
        chk("row1_rows_en", {27'd0, rows_enable}, 32'h03);

        // Back-to-back column frames in one select
        session("cols", 2, 16'h2081, 16'h2180);
        latch_pulse();
        chk("cols_hb", {28'd0, cols_hbrige}, 32'h1);
        chk("cols_en", {30'd0, cols_enable}, 32'h3);

        // Out-of-range row and invalid command
        session("badaddr", 1, 16'h1780, 16'h0);
        chk("badaddr_err", {31'd0, frame_err}, 32'h1);
        session("badcmd", 1, 16'h9000, 16'h0);
        latch_pulse();
        chk("bad_rows", {22'd0, rows_hbrige}, 32'h00A);
        chk("bad_cols", {28'd0, cols_hbrige}, 32'h1);
        chk("bad_err", {31'd0, frame_err}, 32'h1);

        // Abort after 9 bits, then a full row-3 frame
        spi.ss_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 9; i++) begin
            spi.mosi = 1'b1;
            wait_clk(HALF);
            spi.sclk = 1'b1;
            wait_clk(HALF);
            spi.sclk = 1'b0;
        end
        wait_clk(HALF);
        spi.ss_n = 1'b1;
        m_err = 1'b1;
        wait_clk(2 * HALF);
        chk("abort_miso_idle", {31'd0, spi.miso}, 32'h0);
        session("row3", 1, 16'h1382, 16'h0);
        latch_pulse();
        chk("row3_rows", {22'd0, rows_hbrige}, 32'h08A);
        chk("row3_rows_en", {27'd0, rows_enable}, 32'h0B);
        chk("row3_err", {31'd0, frame_err}, 32'h1);

        // Global output enable
        spi.enable_n = 1'b1;
        wait_clk(4);
        chk("dis_rows", {22'd0, rows_hbrige}, 32'h0);
        chk("dis_rows_en", {27'd0, rows_enable}, 32'h0);
        chk("dis_cols", {28'd0, cols_hbrige}, 32'h0);
        chk("dis_cols_en", {30'd0, cols_enable}, 32'h0);
        spi.enable_n = 1'b0;
        wait_clk(3);
        chk("reen_rows", {22'd0, rows_hbrige}, 32'h08A);

        // Clear all shadows
        session("clear", 1, 16'h4000, 16'h0);
        latch_pulse();
        chk("clear_rows", {22'd0, rows_hbrige}, 32'h0);
        chk("clear_cols_en", {30'd0, cols_enable}, 32'h0);

        // Reset in the middle of a frame
        session("pre_rst", 1, 16'h1082, 16'h0);
        spi.ss_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 5; i++) begin
            spi.mosi = 1'b0;
            wait_clk(HALF);
            spi.sclk = 1'b1;
            wait_clk(HALF);
            spi.sclk = 1'b0;
        end
        reset_n = 1'b0;
        spi.ss_n = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        m_err = 1'b0;
        m_cnt = 8'd0;
        wait_clk(6);
        latch_pulse();
        chk("midrst_rows", {22'd0, rows_hbrige}, 32'h0);
        chk("midrst_err", {31'd0, frame_err}, 32'h0);
        session("post_rst", 1, 16'h0000, 16'h0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
